uart_byte_receiver: RTL and testbench

//  Serial-to-byte front end: oversamples an asynchronous UART line, recovers 8N1 frames, presents each byte
//  on data_out with a one-cycle data_done pulse. Sits directly upstream of the 3-byte receive buffer, which

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_byte_receiver.sv | 154 +++++++++++++++
 tb/tb_uart_byte_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM encoding, data width, tick divisor helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    function automatic int tick_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator, one-cycle pulse every TICK_DIV clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW       = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 1 || (CLK_HZ % (BAUD * OVERSAMPLE)) != 0) begin : g_bad_div
        $error("uart_baud_tick: CLK_HZ must be an integer multiple (>=1) of BAUD*OVERSAMPLE");
    end

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - oversampling UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_done,
    output logic       frame_error,
    output logic       busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_byte_receiver: OVERSAMPLE must be even and >= 8");
    end

    logic                 w_tick;
    logic                 w_rx;
    logic                 w_mid;
    logic [1:0]           r_sync;
    state_t               r_state;
    logic [SW-1:0]        r_scnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data;
    logic                 r_done;
    logic                 r_ferr;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
`endif

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .i_clk (clk),
        .i_rst (rst),
        .o_tick(w_tick)
    );

    assign w_rx  = r_sync[1];
    assign w_mid = (r_scnt == MID_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= ST_IDLE;
            r_scnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], rx};
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            // Mid-bit counter for DATA/PARITY/STOP; START uses its own half-bit point
            if (w_tick && r_state != ST_IDLE && r_state != ST_START && r_state != ST_BREAK) begin
                r_scnt <= w_mid ? '0 : r_scnt + SW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_scnt <= '0;
                    if (!w_rx) r_state <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_scnt == MID_START) begin
                            r_scnt <= '0;
                            if (w_rx) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DATA;
                                r_busy  <= 1'b1;
                                r_bit   <= '0;
                            end
                        end else begin
                            r_scnt <= r_scnt + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick && w_mid) begin
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (r_bit == 3'd7) r_state <= ST_PARITY;
`else
                        if (r_bit == 3'd7) r_state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick && w_mid) begin
                        r_par   <= w_rx;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick && w_mid) begin
`ifdef UART_RX_PARITY_EN
                        if (w_rx && ((^r_shift) ^ r_par) == 1'b0) begin
`else
                        if (w_rx) begin
`endif
                            r_data  <= r_shift;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    r_scnt <= '0;
                    if (w_rx) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign data_done   = r_done;
    assign frame_error = r_ferr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - scoreboard bench for uart_byte_receiver (16 clk/bit), parity cases under UART_RX_PARITY_EN
module tb_uart_byte_receiver;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    localparam int EXP_LAT = 2 + (BIT_CLKS / 2 + FRAME_BITS * BIT_CLKS) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_done;
    logic       frame_error;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_ferr = 0;
    int done_cyc = 0;
    logic [7:0] exp_q[$];

    uart_byte_receiver #(
        .CLK_HZ    (16_000_000),
        .BAUD      (1_000_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_done  (data_done),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: each data_done pops the next expected byte
    always @(negedge clk) begin
        if (!rst) begin
            if (data_done) begin
                n_done++;
                done_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got data_done with byte %h, required no pulse", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        bad++;
                        $display("FAIL sb_byte: got %h required %h", data_out, e);
                    end
                end
            end
            if (frame_error) n_ferr++;
            if (data_done && frame_error) begin
                total++;
                bad++;
                $display("FAIL sb_overlap: data_done=1 frame_error=1, required not both");
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        if (stop && !par_flip) exp_q.push_back(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        total += 4;
        if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data: got %h required 00", data_out); end
        if (data_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", data_done); end
        if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b required 0", frame_error); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single;
        int d0, f0, start;
        d0 = n_done; f0 = n_ferr;
        start = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_int("single_done_cnt", n_done - d0, 1);
        check_int("single_ferr_cnt", n_ferr - f0, 0);
        check_int("single_latency", done_cyc - start, EXP_LAT);
        check_int("single_q_empty", exp_q.size(), 0);
        total++;
        if (data_out !== 8'hA5) begin bad++; $display("FAIL single_data: got %h required a5", data_out); end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = n_done;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_int("b2b_done_cnt", n_done - d0, 3);
        check_int("b2b_q_empty", exp_q.size(), 0);
        total++;
        if (data_out !== 8'h3C) begin bad++; $display("FAIL b2b_data: got %h required 3c", data_out); end
    endtask

    task automatic test_glitch;
        int d0, f0;
        logic saw_busy;
        d0 = n_done; f0 = n_ferr;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check_int("glitch_done_cnt", n_done - d0, 0);
        check_int("glitch_ferr_cnt", n_ferr - f0, 0);
        check_int("glitch_busy", int'(saw_busy), 0);
    endtask

    task automatic test_break;
        int d0, f0;
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h5A, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check_int("break_ferr_cnt", n_ferr - f0, 1);
        check_int("break_done_cnt", n_done - d0, 0);
        total++;
        if (data_out !== 8'h3C) begin bad++; $display("FAIL break_data_kept: got %h required 3c", data_out); end
        rx = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h77, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_int("break_next_done", n_done - d0, 1);
        check_int("break_next_ferr", n_ferr - f0, 1);
        total++;
        if (data_out !== 8'h77) begin bad++; $display("FAIL break_next_data: got %h required 77", data_out); end
    endtask

    task automatic test_reset_midframe;
        int d0, f0;
        logic [7:0] b;
        b = 8'hC3;
        d0 = n_done; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rx = b[4];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        total += 4;
        if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h required 00", data_out); end
        if (data_done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b required 0", data_done); end
        if (frame_error !== 1'b0) begin bad++; $display("FAIL midrst_ferr: got %b required 0", frame_error); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_int("midrst_no_pulse", (n_done - d0) + (n_ferr - f0), 0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_int("midrst_next_done", n_done - d0, 1);
        total++;
        if (data_out !== 8'h12) begin bad++; $display("FAIL midrst_next_data: got %h required 12", data_out); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int d0, f0;
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (32) @(negedge clk);
        check_int("par_good_done", n_done - d0, 1);
        check_int("par_good_ferr", n_ferr - f0, 0);
        send_frame(8'h0F, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        check_int("par_bad_done", n_done - d0, 1);
        check_int("par_bad_ferr", n_ferr - f0, 1);
        total++;
        if (data_out !== 8'h0F) begin bad++; $display("FAIL par_data: got %h required 0f", data_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        check_int("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
